spi_sensor_target: RTL and testbench

SPI mode-0 target (responder) with a 16 × 8-bit register file, modelling the peripheral end of the sensor SPI link. It decodes the address-byte-then-data-bytes frame the bus bridge emits, commits writes, and returns register and sensor data on MISO. It serves as the on-chip loopback target for the bridge in system simulation and as a reusable SPI sensor front end.

---
 rtl/spi_sensor_target.sv | 158 +++++++++++++++
 tb/tb_spi_sensor_target.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_target.sv
// SPI mode-0 target with a 16x8 register file; optional SPI_TARGET_SYNC_EN adds a 2-flop input synchroniser.
// Latency: commit and MISO update 2 clk after an SCLK edge at the pins (4 clk with SPI_TARGET_SYNC_EN).
// Backpressure: none; the initiator owns SCLK pacing (>= 2 clk per SCLK, >= 8 clk with the synchroniser).
module spi_sensor_target (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sensor_clk,
    input  logic        spi_sensor_cs_n,
    input  logic        spi_sensor_mosi,
    output logic        spi_sensor_miso,
    input  logic [15:0] sensor_data,
    output logic        reg_wr_valid,
    output logic [3:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);
    localparam logic [7:0] DEVICE_ID = 8'hA5;

    typedef enum logic [1:0] {IDLE, ADDR, WR, RD} state_t;

    logic sclk_in, cs_in, mosi_in;

`ifdef SPI_TARGET_SYNC_EN
    logic [1:0] sclk_sync, cs_sync, mosi_sync;

    // Chip-select stages reset low so a frame already running at reset release never looks like a new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sensor_clk};
            cs_sync   <= {cs_sync[0], spi_sensor_cs_n};
            mosi_sync <= {mosi_sync[0], spi_sensor_mosi};
        end
    end

    assign sclk_in = sclk_sync[1];
    assign cs_in   = cs_sync[1];
    assign mosi_in = mosi_sync[1];
`else
    assign sclk_in = spi_sensor_clk;
    assign cs_in   = spi_sensor_cs_n;
    assign mosi_in = spi_sensor_mosi;
`endif

    state_t      state;
    logic        sclk_q, sclk_qq, cs_q, cs_qq, mosi_q;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sh;
    logic [7:0]  tx_sh;
    logic [3:0]  ptr;
    logic [15:0] snap;
    logic [7:0]  regs [16];

    logic       rise, fall, cs_fall, cs_rise, byte_done;
    logic [7:0] rx_byte;

    assign rise      = sclk_q & ~sclk_qq;
    assign fall      = ~sclk_q & sclk_qq;
    assign cs_fall   = ~cs_q & cs_qq;
    assign cs_rise   = cs_q & ~cs_qq;
    assign rx_byte   = {rx_sh, mosi_q};
    assign byte_done = rise && (bit_cnt == 3'd7) && (state != IDLE);

    function automatic logic [7:0] read_reg(input logic [3:0] idx);
        case (idx)
            4'h0:    read_reg = DEVICE_ID;
            4'h1:    read_reg = snap[15:8];
            4'h2:    read_reg = snap[7:0];
            default: read_reg = regs[idx];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            sclk_q          <= 1'b0;
            sclk_qq         <= 1'b0;
            cs_q            <= 1'b0;
            cs_qq           <= 1'b0;
            mosi_q          <= 1'b0;
            bit_cnt         <= 3'd0;
            rx_sh           <= 7'd0;
            tx_sh           <= 8'd0;
            ptr             <= 4'd0;
            snap            <= 16'd0;
            spi_sensor_miso <= 1'b0;
            reg_wr_valid    <= 1'b0;
            reg_wr_addr     <= 4'd0;
            reg_wr_data     <= 8'd0;
            busy            <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            sclk_q       <= sclk_in;
            sclk_qq      <= sclk_q;
            cs_q         <= cs_in;
            cs_qq        <= cs_q;
            mosi_q       <= mosi_in;
            busy         <= ~cs_in;
            reg_wr_valid <= 1'b0;

            if (cs_rise) begin
                state           <= IDLE;
                bit_cnt         <= 3'd0;
                spi_sensor_miso <= 1'b0;
            end else if (cs_fall) begin
                // Any SCLK rise in this cycle is deliberately dropped: frame start only.
                state           <= ADDR;
                bit_cnt         <= 3'd0;
                snap            <= sensor_data;
                spi_sensor_miso <= 1'b0;
            end else begin
                if (rise && state != IDLE) begin
                    rx_sh   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    case (state)
                        ADDR: begin
                            if (rx_byte[7]) begin
                                state <= RD;
                                tx_sh <= read_reg(rx_byte[3:0]);
                                ptr   <= rx_byte[3:0] + 4'd1;
                            end else begin
                                state <= WR;
                                ptr   <= rx_byte[3:0];
                            end
                        end
                        WR: begin
                            reg_wr_valid <= 1'b1;
                            reg_wr_addr  <= ptr;
                            reg_wr_data  <= rx_byte;
                            if (ptr > 4'd2) regs[ptr] <= rx_byte;
                            ptr <= ptr + 4'd1;
                        end
                        RD: begin
                            tx_sh <= read_reg(ptr);
                            ptr   <= ptr + 4'd1;
                        end
                        default: state <= IDLE;
                    endcase
                end

                if (fall) begin
                    if (state == RD) begin
                        spi_sensor_miso <= tx_sh[7];
                        tx_sh           <= {tx_sh[6:0], 1'b0};
                    end else begin
                        spi_sensor_miso <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_sensor_target.sv
// Randomised bench for spi_sensor_target: a frame-level model predicts commits, MISO bits and busy per cycle.
module tb_spi_sensor_target;
`ifdef SPI_TARGET_SYNC_EN
    localparam int H    = 4;
    localparam int LAT  = 4;
    localparam int LATB = 3;
`else
    localparam int H    = 1;
    localparam int LAT  = 2;
    localparam int LATB = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_sensor_clk, spi_sensor_cs_n, spi_sensor_mosi;
    logic        spi_sensor_miso;
    logic [15:0] sensor_data;
    logic        reg_wr_valid;
    logic [3:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy;

    spi_sensor_target dut (
        .clk             (clk),
        .reset           (reset),
        .spi_sensor_clk  (spi_sensor_clk),
        .spi_sensor_cs_n (spi_sensor_cs_n),
        .spi_sensor_mosi (spi_sensor_mosi),
        .spi_sensor_miso (spi_sensor_miso),
        .sensor_data     (sensor_data),
        .reg_wr_valid    (reg_wr_valid),
        .reg_wr_addr     (reg_wr_addr),
        .reg_wr_data     (reg_wr_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { int cyc; logic b; int bitpos; bit rd; } mi_t;
    wr_t        wq[$];
    mi_t        mq[$];
    logic [7:0] got[$];

    int         total = 0, bad = 0, wr_pulses = 0, since_rst = 0;
    logic [7:0] mregs [16];
    logic [15:0] msnap, mid_sensor;
    logic [3:0] last_a;
    logic [7:0] last_d, acc;
    logic       cs_hist [4];
    logic [7:0] fb [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mread(input logic [3:0] i);
        case (i)
            4'h0:    mread = 8'hA5;
            4'h1:    mread = msnap[15:8];
            4'h2:    mread = msnap[7:0];
            default: mread = mregs[i];
        endcase
    endfunction

    function automatic logic [7:0] gb(input int i);
        gb = (got.size() > i) ? got[i] : 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycle-by-cycle compare against the expectation queues.
    initial begin
        last_a = 4'd0;
        last_d = 8'd0;
        acc    = 8'd0;
        for (int i = 0; i < 4; i++) cs_hist[i] = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                since_rst = 0;
                last_a    = 4'd0;
                last_d    = 8'd0;
            end else begin
                since_rst++;
                check("wr_valid", {31'd0, reg_wr_valid},
                      {31'd0, (wq.size() > 0 && wq[0].cyc == cyc)});
                if (reg_wr_valid) wr_pulses++;
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    last_a = wq[0].a;
                    last_d = wq[0].d;
                    void'(wq.pop_front());
                end
                check("wr_addr", {28'd0, reg_wr_addr}, {28'd0, last_a});
                check("wr_data", {24'd0, reg_wr_data}, {24'd0, last_d});
                if (since_rst > 4)
                    check("busy", {31'd0, busy}, {31'd0, ~cs_hist[LATB-1]});
                if (mq.size() > 0 && mq[0].cyc == cyc) begin
                    check("miso", {31'd0, spi_sensor_miso}, {31'd0, mq[0].b});
                    if (mq[0].rd) begin
                        acc = (mq[0].bitpos == 7) ? {7'd0, spi_sensor_miso} : {acc[6:0], spi_sensor_miso};
                        if (mq[0].bitpos == 0) got.push_back(acc);
                    end
                    void'(mq.pop_front());
                end
            end
            for (int i = 3; i > 0; i--) cs_hist[i] = cs_hist[i-1];
            cs_hist[0] = spi_sensor_cs_n;
        end
    end

    // Drives one frame of nbits bits from fb[] and records what the target must do.
    task automatic frame(input int nbits);
        logic [7:0] a, cur, dbyte;
        logic [3:0] idx;
        int d, m;
        a = fb[0];
        msnap = sensor_data;
        got.delete();
        spi_sensor_cs_n = 1'b0;
        spi_sensor_clk  = 1'b0;
        for (int j = 0; j < nbits; j++) begin
            cur = fb[j/8];
            spi_sensor_mosi = cur[7 - j%8];
            tick(H);
            spi_sensor_clk = 1'b1;
            if (j == 3) sensor_data = mid_sensor;
            if (!a[7] && j >= 15 && (j % 8) == 7) begin
                m     = (j - 15) / 8;
                idx   = a[3:0] + 4'(m);
                dbyte = fb[m+1];
                wq.push_back('{cyc + LAT, idx, dbyte});
                if (idx > 4'd2) mregs[idx] = dbyte;
            end
            tick(H);
            spi_sensor_clk = 1'b0;
            if (j < 7) begin
                mq.push_back('{cyc + LAT, 1'b0, 0, 1'b0});
            end else if (a[7]) begin
                d   = j - 7;
                cur = mread(a[3:0] + 4'(d/8));
                mq.push_back('{cyc + LAT, cur[7 - d%8], 7 - d%8, 1'b1});
            end
        end
        tick(H);
        spi_sensor_cs_n = 1'b1;
        tick(2*LAT + 4);
    endtask

    int p0;

    initial begin
        reset = 1'b1;
        spi_sensor_clk  = 1'b0;
        spi_sensor_cs_n = 1'b1;
        spi_sensor_mosi = 1'b0;
        sensor_data     = 16'h0;
        mid_sensor      = 16'h0;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;
        tick(3);
        check("rst_miso",  {31'd0, spi_sensor_miso}, 32'd0);
        check("rst_valid", {31'd0, reg_wr_valid}, 32'd0);
        check("rst_addr",  {28'd0, reg_wr_addr}, 32'd0);
        check("rst_data",  {24'd0, reg_wr_data}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(8);

        fb[0] = 8'h80; fb[1] = 8'h00;
        frame(16);
        check("id_read", {24'd0, gb(0)}, 32'hA5);

        p0 = wr_pulses;
        fb[0] = 8'h05; fb[1] = 8'h3C;
        frame(16);
        check("wr1_pulses", wr_pulses - p0, 32'd1);
        check("wr1_model", {24'd0, mregs[5]}, 32'h3C);
        fb[0] = 8'h85;
        frame(16);
        check("rd5", {24'd0, gb(0)}, 32'h3C);

        p0 = wr_pulses;
        fb[0] = 8'h0E; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
        frame(32);
        check("burst_pulses", wr_pulses - p0, 32'd3);
        fb[0] = 8'h8E;
        frame(32);
        check("burst_rdE", {24'd0, gb(0)}, 32'h11);
        check("burst_rdF", {24'd0, gb(1)}, 32'h22);
        check("burst_rd0", {24'd0, gb(2)}, 32'hA5);

        sensor_data = 16'h1234; mid_sensor = 16'hFFFF;
        tick(4);
        fb[0] = 8'h81;
        frame(24);
        check("snap_hi", {24'd0, gb(0)}, 32'h12);
        check("snap_lo", {24'd0, gb(1)}, 32'h34);

        p0 = wr_pulses;
        fb[0] = 8'h07; fb[1] = 8'hFF;
        frame(13);
        check("abort_pulses", wr_pulses - p0, 32'd0);
        fb[0] = 8'h87;
        frame(16);
        check("abort_reg7", {24'd0, gb(0)}, 32'h00);
        p0 = wr_pulses;
        fb[0] = 8'h07; fb[1] = 8'h5A;
        frame(16);
        check("rewr_pulses", wr_pulses - p0, 32'd1);
        fb[0] = 8'h87;
        frame(16);
        check("rewr_reg7", {24'd0, gb(0)}, 32'h5A);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
            sensor_data = 16'($urandom);
            mid_sensor  = 16'($urandom);
            tick(4);
            if ($urandom_range(0, 3) == 0) frame($urandom_range(1, 40));
            else frame(8 + 8 * $urandom_range(0, 4));
        end

        tick(10);
        check("wq_drained", wq.size(), 32'd0);
        check("mq_drained", mq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
